// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter for I-cache fills and D-cache fills/writebacks.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default is DC priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ready,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ready,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            own_dc;
  logic            grant_dc;
  logic            any_req;
  logic [WD_W-1:0] wd_cnt;

  assign any_req = ic_req | dc_req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dc;

  assign grant_dc = dc_req & (~ic_req | ~last_dc);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_dc <= 1'b1;
    end else if (state_q == IDLE && any_req) begin
      last_dc <= grant_dc;
    end
  end
`else
  assign grant_dc = dc_req;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   if (mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req  = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign ic_ready = (state_q == DONE) & ~own_dc;
  assign dc_ready = (state_q == DONE) & own_dc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      own_dc    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (state_q == IDLE && any_req) begin
      own_dc    <= grant_dc;
      mem_we    <= grant_dc & dc_we;
      mem_addr  <= grant_dc ? dc_addr : ic_addr;
      mem_wdata <= grant_dc ? dc_wdata : '0;
    end
  end

  // writebacks complete without touching dc_rdata
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_rdata <= '0;
      dc_rdata <= '0;
    end else if (state_q == ISSUE && mem_ack) begin
      if (!own_dc) begin
        ic_rdata <= mem_rdata;
      end else if (!mem_we) begin
        dc_rdata <= mem_rdata;
      end
    end
  end

  // counter saturates; err is sticky and the FSM keeps waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else if (state_q == ISSUE && !mem_ack) begin
      if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_LAST) err <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
// Table of lone-requester transactions plus hand sequences for corners.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic         ic_ready;
  logic [127:0] ic_rdata;
  logic         dc_req;
  logic         dc_we;
  logic [31:0]  dc_addr;
  logic [127:0] dc_wdata;
  logic         dc_ready;
  logic [127:0] dc_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_ack;
  logic [127:0] mem_rdata;
  logic         busy;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_ic;
  logic [127:0] exp_dc;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .LINE_W(128), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .ic_ready(ic_ready), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we),
    .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  typedef struct {
    logic         ic_req;
    logic         dc_req;
    logic         dc_we;
    logic [31:0]  ic_addr;
    logic [31:0]  dc_addr;
    logic [127:0] dc_wdata;
    int           lat;
    logic [127:0] line;
    logic         exp_dc;
    logic         exp_we;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ic_req = 1'b0;
    dc_req = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_ic = '0;
    exp_dc = '0;
  endtask

  // entered at the negedge of the first ISSUE cycle; returns in DONE
  task automatic serve(input logic e_dc, input int lat,
                       input logic [127:0] line, input logic e_we,
                       input logic [31:0] e_addr,
                       input logic [127:0] e_wdata);
    chk("mem_req", mem_req, 1);
    chk("busy_issue", busy, 1);
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("mem_req_hold", mem_req, 1);
      chk("mem_addr_hold", mem_addr, e_addr);
      chk("no_early_ready", ic_ready | dc_ready, 0);
    end
    mem_ack = 1'b1;
    mem_rdata = line;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = ~line;
    if (!e_dc) exp_ic = line;
    else if (!e_we) exp_dc = line;
    chk("ic_ready", ic_ready, !e_dc);
    chk("dc_ready", dc_ready, e_dc);
    chk("mem_req_done", mem_req, 0);
    chk("ic_rdata", ic_rdata, exp_ic);
    chk("dc_rdata", dc_rdata, exp_dc);
  endtask

  task automatic idle_after(input logic drop_ic, input logic drop_dc);
    @(negedge clk);
    if (drop_ic) ic_req = 1'b0;
    if (drop_dc) dc_req = 1'b0;
    chk("ready_one_cycle", ic_ready | dc_ready, 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic run_tie(input logic first_dc, input logic [31:0] ia,
                         input logic [31:0] da);
    ic_req = 1'b1;
    ic_addr = ia;
    dc_req = 1'b1;
    dc_we = 1'b0;
    dc_addr = da;
    @(negedge clk);
    serve(first_dc, 1, {96'h0, ia}, 1'b0, first_dc ? da : ia, '0);
    idle_after(!first_dc, first_dc);
    @(negedge clk);
    serve(!first_dc, 1, {96'h0, da}, 1'b0, first_dc ? ia : da, '0);
    idle_after(1'b1, 1'b1);
  endtask

  initial begin
    int n;
    time t1;
    logic tie1_dc;
`ifdef ARB_ROUND_ROBIN_EN
    tie1_dc = 1'b0;
`else
    tie1_dc = 1'b1;
`endif
    vecs[0] = '{1, 0, 0, 32'h2000, 32'h0, 128'h0, 4,
                128'h1111_2222_3333_4444_5555_6666_7777_8888,
                0, 0, 32'h2000};
    vecs[1] = '{0, 1, 0, 32'h0, 32'h4000, 128'h0, 1,
                128'hCAFE_0000_0000_0000_0000_0000_0000_F00D,
                1, 0, 32'h4000};
    vecs[2] = '{0, 1, 1, 32'h0, 32'h3010, 128'hDEAD_BEEF, 2,
                128'h0BAD_0BAD, 1, 1, 32'h3010};
    vecs[3] = '{1, 0, 0, 32'h2040, 32'h0, 128'h0, 0,
                128'hABCD_0123, 0, 0, 32'h2040};

    rst = 1'b1;
    ic_req = 1'b0;
    dc_req = 1'b0;
    dc_we = 1'b0;
    ic_addr = '0;
    dc_addr = '0;
    dc_wdata = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_ready", ic_ready | dc_ready, 0);
    chk("rst_ic_rdata", ic_rdata, 0);
    chk("rst_dc_rdata", dc_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    exp_ic = '0;
    exp_dc = '0;

    for (int k = 0; k < 4; k++) begin
      ic_req = vecs[k].ic_req;
      dc_req = vecs[k].dc_req;
      dc_we = vecs[k].dc_we;
      ic_addr = vecs[k].ic_addr;
      dc_addr = vecs[k].dc_addr;
      dc_wdata = vecs[k].dc_wdata;
      @(negedge clk);
      serve(vecs[k].exp_dc, vecs[k].lat, vecs[k].line,
            vecs[k].exp_we, vecs[k].exp_addr, vecs[k].dc_wdata);
      idle_after(1'b1, 1'b1);
    end

    mem_ack = 1'b1;
    mem_rdata = '1;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ack_busy", busy, 0);
      chk("stray_ack_ready", ic_ready | dc_ready, 0);
      chk("stray_ack_ic_rdata", ic_rdata, exp_ic);
    end
    mem_ack = 1'b0;

    do_reset();
    run_tie(tie1_dc, 32'h5000, 32'h6000);
    ic_req = 1'b1;
    ic_addr = 32'h5040;
    @(negedge clk);
    serve(1'b0, 0, 128'h5040, 1'b0, 32'h5040, '0);
    idle_after(1'b1, 1'b1);
    run_tie(1'b1, 32'h5080, 32'h6080);

    ic_req = 1'b1;
    ic_addr = 32'h8000;
    @(negedge clk);
    serve(1'b0, 0, 128'h8001, 1'b0, 32'h8000, '0);
    t1 = $time;
    @(negedge clk);
    chk("b2b_idle_busy", busy, 0);
    @(negedge clk);
    serve(1'b0, 0, 128'h8002, 1'b0, 32'h8000, '0);
    chk("b2b_period", ($time - t1) / 10, 3);
    idle_after(1'b1, 1'b1);

    dc_req = 1'b1;
    dc_we = 1'b0;
    dc_addr = 32'h7000;
    @(negedge clk);
    chk("rst_mid_req", mem_req, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dc_req = 1'b0;
    exp_ic = '0;
    exp_dc = '0;
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_busy", busy, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_ready", ic_ready | dc_ready, 0);
      chk("rst_mid_idle", busy, 0);
    end

    ic_req = 1'b1;
    ic_addr = 32'h9000;
    @(negedge clk);
    n = 0;
    while (mem_req && !err && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("wd_cycles", n, 64);
    chk("wd_err", err, 1);
    chk("wd_mem_req", mem_req, 1);
    repeat (3) @(negedge clk);
    chk("wd_err_sticky", err, 1);
    chk("wd_still_issue", mem_req, 1);
    do_reset();
    chk("wd_rst_err", err, 0);
    chk("wd_rst_mem_req", mem_req, 0);
    chk("wd_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
